// File: rtl/req_encoder_32to5_pkg.sv
// Shared sizes, FSM state encoding and helpers for the 32-to-5 request encoder.
// Optional feature macro used by the top: REQ_ENC_MASK_EN (adds a request mask input).
package req_encoder_32to5_pkg;

    localparam int unsigned NUM_REQ = 32;
    localparam int unsigned IDX_W   = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Payload presented to the consumer.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } out_beat_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/req_encoder_32to5_ffs_encoder.sv
// Combinational find-first-set: lowest set bit of vec_i wins, any_c_o flags a non-empty vector.
module ffs_encoder
    import req_encoder_32to5_pkg::*;
#(
    parameter int unsigned N_IN  = NUM_REQ,
    parameter int unsigned IDX_N = IDX_W
) (
    input  logic [N_IN-1:0]  vec_i,
    output logic [IDX_N-1:0] idx_c_o,
    output logic             any_c_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_c_o = '0;
        any_c_o = |vec_i;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_c_o = IDX_N'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder_32to5.sv
// Collects request pulses into a pending set and hands out the lowest pending index over valid/ready.
// Build option: define REQ_ENC_MASK_EN to add mask_i (masked bits stay pending but are not selected).
module req_encoder_32to5
    import req_encoder_32to5_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
`ifdef REQ_ENC_MASK_EN
    input  logic [NUM_REQ-1:0] mask_i,
`endif
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [IDX_W-1:0]   out_idx_o,
    output logic [NUM_REQ-1:0] pending_o
);

    state_e             state_q, state_d;
    out_beat_t          out_q;
    logic [IDX_W-1:0]   out_idx_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;

    logic               accept_c;
    logic [NUM_REQ-1:0] clr_c;
    logic [NUM_REQ-1:0] elig_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic               sel_any_c;

    assign accept_c = (state_q == ST_HOLD) && out_ready_i;
    assign clr_c    = accept_c ? onehot(out_q.idx) : '0;

    // Set wins over clear, so a same-cycle re-request of the accepted bit survives.
    assign pending_d = (pending_q & ~clr_c) | req_i;

`ifdef REQ_ENC_MASK_EN
    assign elig_c = pending_q & ~clr_c & ~mask_i;
`else
    assign elig_c = pending_q & ~clr_c;
`endif

    ffs_encoder #(
        .N_IN  (NUM_REQ),
        .IDX_N (IDX_W)
    ) u_ffs (
        .vec_i   (elig_c),
        .idx_c_o (sel_idx_c),
        .any_c_o (sel_any_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= '{valid: (state_d == ST_HOLD), idx: out_idx_d};
            pending_q <= pending_d;
        end
    end

    // HOLD freezes the index until accepted; an accept with more work reloads without a bubble.
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_q.idx;
        case (state_q)
            ST_IDLE: begin
                if (sel_any_c) begin
                    out_idx_d = sel_idx_c;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    if (sel_any_c) begin
                        out_idx_d = sel_idx_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    assign out_valid_o = out_q.valid;
    assign out_idx_o   = out_q.idx;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Self-checking bench for req_encoder_32to5: expected indices queued on stimulus, popped on accept.
module tb_req_encoder_32to5;
    import req_encoder_32to5_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] mask;
    logic               out_ready;
    logic               out_valid;
    logic [IDX_W-1:0]   out_idx;
    logic [NUM_REQ-1:0] pending;

    int unsigned        vectors = 0;
    int unsigned        miscompares = 0;
    int unsigned        exp_q[$];

    always #5 clk = ~clk;

    req_encoder_32to5 dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
`ifdef REQ_ENC_MASK_EN
        .mask_i      (mask),
`endif
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_idx_o   (out_idx),
        .pending_o   (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; out_ready = 1'b0; mask = '0;
        tick(); tick();
        rst = 1'b0; req = '0;
        vectors++;
        if (pending !== '0 || out_valid !== 1'b0 || out_idx !== '0) begin
            miscompares++;
            $display("FAIL reset: pending=%h valid=%b idx=%0d expected 0/0/0", pending, out_valid, out_idx);
        end
        tick();
        vectors++;
        if (pending !== '0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: pending=%h valid=%b expected 0/0", pending, out_valid);
        end
    endtask

    task automatic test_single();
        int unsigned e;
        req = 32'h0000_0080; out_ready = 1'b0;
        exp_q.push_back(7);
        tick();
        req = '0;
        vectors++;
        if (pending !== 32'h0000_0080 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_lat1: pending=%h valid=%b expected 00000080/0", pending, out_valid);
        end
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7) begin
            miscompares++;
            $display("FAIL single_hold: valid=%b idx=%0d expected 1/7", out_valid, out_idx);
        end
        out_ready = 1'b1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL single_pop: scoreboard empty, idx=%0d", out_idx);
        end else begin
            e = exp_q.pop_front();
            if (out_idx !== IDX_W'(e)) begin
                miscompares++;
                $display("FAIL single_pop: idx=%0d expected %0d", out_idx, e);
            end
        end
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || pending !== '0) begin
            miscompares++;
            $display("FAIL single_done: valid=%b pending=%h expected 0/0", out_valid, pending);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned e;
        req = 32'h8000_0011; out_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(31);
        tick();
        req = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_beat%0d: valid=%b queued=%0d expected valid 1", k, out_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (out_idx !== IDX_W'(e)) begin
                    miscompares++;
                    $display("FAIL b2b_beat%0d: idx=%0d expected %0d", k, out_idx, e);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || pending !== '0) begin
            miscompares++;
            $display("FAIL b2b_done: valid=%b pending=%h expected 0/0", out_valid, pending);
        end
    endtask

    task automatic test_hold_priority();
        int unsigned e;
        req = 32'h0000_0010; out_ready = 1'b0;
        exp_q.push_back(4);
        tick();
        req = '0;
        tick();
        req = 32'h0000_0002;
        exp_q.push_back(1);
        tick();
        req = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd4 || pending !== 32'h0000_0012) begin
            miscompares++;
            $display("FAIL hold_frozen: valid=%b idx=%0d pending=%h expected 1/4/00000012", out_valid, out_idx, pending);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL hold_beat%0d: valid=%b queued=%0d expected valid 1", k, out_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if (out_idx !== IDX_W'(e)) begin
                    miscompares++;
                    $display("FAIL hold_beat%0d: idx=%0d expected %0d", k, out_idx, e);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_done: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rerequest();
        int unsigned e;
        req = 32'h0000_0010; out_ready = 1'b0;
        exp_q.push_back(4);
        tick();
        req = '0;
        tick();
        out_ready = 1'b1; req = 32'h0000_0010;
        exp_q.push_back(4);
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 99;
        if (out_valid !== 1'b1 || out_idx !== IDX_W'(e)) begin
            miscompares++;
            $display("FAIL rereq_accept: valid=%b idx=%0d expected 1/%0d", out_valid, out_idx, e);
        end
        tick();
        req = '0;
        vectors++;
        if (pending !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL rereq_pending: pending=%h expected 00000010", pending);
        end
        tick();
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 99;
        if (out_valid !== 1'b1 || out_idx !== IDX_W'(e)) begin
            miscompares++;
            $display("FAIL rereq_reissue: valid=%b idx=%0d expected 1/%0d", out_valid, out_idx, e);
        end
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || pending !== '0) begin
            miscompares++;
            $display("FAIL rereq_done: valid=%b pending=%h expected 0/0", out_valid, pending);
        end
    endtask

    task automatic test_reset_in_hold();
        req = 32'h0000_0200; out_ready = 1'b0;
        tick();
        req = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd9) begin
            miscompares++;
            $display("FAIL rsthold_pre: valid=%b idx=%0d expected 1/9", out_valid, out_idx);
        end
        rst = 1'b1; req = 32'h0000_0002;
        tick();
        rst = 1'b0; req = '0;
        vectors++;
        if (out_valid !== 1'b0 || pending !== '0 || out_idx !== '0) begin
            miscompares++;
            $display("FAIL rsthold_reset: valid=%b pending=%h idx=%0d expected 0/0/0", out_valid, pending, out_idx);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rsthold_after%0d: valid=%b idx=%0d expected valid 0", k, out_valid, out_idx);
            end
        end
    endtask

    task automatic test_random_burst();
        logic [NUM_REQ-1:0] pat;
        logic [NUM_REQ-1:0] one;
        int unsigned        e;
        for (int r = 0; r < 3; r++) begin
            one = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
            pat = NUM_REQ'($urandom()) | one;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (pat[i]) exp_q.push_back(i);
            end
            req = pat; out_ready = 1'b1;
            tick();
            req = '0;
            for (int c = 0; c < 45 && exp_q.size() != 0; c++) begin
                if (out_valid === 1'b1) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (out_idx !== IDX_W'(e)) begin
                        miscompares++;
                        $display("FAIL rand%0d_idx: idx=%0d expected %0d", r, out_idx, e);
                    end
                end
                tick();
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL rand%0d_timeout: %0d indices never issued", r, exp_q.size());
                exp_q.delete();
            end
            vectors++;
            if (out_valid !== 1'b0 || pending !== '0) begin
                miscompares++;
                $display("FAIL rand%0d_done: valid=%b pending=%h expected 0/0", r, out_valid, pending);
            end
            out_ready = 1'b0;
            tick();
        end
    endtask

`ifdef REQ_ENC_MASK_EN
    task automatic test_mask();
        req = 32'h0000_0003; mask = 32'h0000_0001; out_ready = 1'b0;
        tick();
        req = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd1) begin
            miscompares++;
            $display("FAIL mask_sel: valid=%b idx=%0d expected 1/1", out_valid, out_idx);
        end
        out_ready = 1'b1; mask = '0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0) begin
            miscompares++;
            $display("FAIL mask_unmask: valid=%b idx=%0d expected 1/0", out_valid, out_idx);
        end
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || pending !== '0) begin
            miscompares++;
            $display("FAIL mask_done: valid=%b pending=%h expected 0/0", out_valid, pending);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; mask = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_priority();
        test_rerequest();
        test_reset_in_hold();
        test_random_burst();
`ifdef REQ_ENC_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
